// File: rtl/simplified_aes_enc_iter_if.sv
// Plaintext/ciphertext handshake bundle for the iterative S-AES encryptor.
// The master side is the plaintext source plus ciphertext sink; the slave
// side is the encryptor itself.
interface simplified_aes_enc_iter_if;
   logic [15:0] Plain_Text;
   logic [15:0] Key;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] Cipher_Text;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   modport master (
      output Plain_Text, Key, in_valid, out_ready,
      input  in_ready, Cipher_Text, out_valid, busy
   );

   modport slave (
      input  Plain_Text, Key, in_valid, out_ready,
      output in_ready, Cipher_Text, out_valid, busy
   );
endinterface

// File: rtl/simplified_aes_enc_iter.sv
// Iterative simplified-AES encryptor: one round per clock.
// The key schedule, nibble order and round keys K0/K1/K2 match the
// combinational S-AES decryptor, so ciphertext from this block decrypts
// back to the original plaintext.
module simplified_aes_enc_iter #(
   parameter logic [7:0] RCON1 = 8'h80,
   parameter logic [7:0] RCON2 = 8'h30
) (
   input  logic                             clk,
   input  logic                             rst,
   simplified_aes_enc_iter_if.slave         bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND1 = 2'd1,
      ROUND2 = 2'd2,
      DONE   = 2'd3
   } state_t;

   // 4-bit S-box
   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0:    r = 4'h9;
         4'h1:    r = 4'h4;
         4'h2:    r = 4'hA;
         4'h3:    r = 4'hB;
         4'h4:    r = 4'hD;
         4'h5:    r = 4'h1;
         4'h6:    r = 4'h8;
         4'h7:    r = 4'h5;
         4'h8:    r = 4'h6;
         4'h9:    r = 4'h2;
         4'hA:    r = 4'h0;
         4'hB:    r = 4'h3;
         4'hC:    r = 4'hC;
         4'hD:    r = 4'hE;
         4'hE:    r = 4'hF;
         4'hF:    r = 4'h7;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   // S-box applied to each nibble of the 16-bit state
   function automatic logic [15:0] sub_nib16(input logic [15:0] s);
      return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
   endfunction

   // {n0,n1,n2,n3} -> {n0,n3,n2,n1}
   function automatic logic [15:0] shift_row(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   // Multiply by x in GF(2^4) mod x^4+x+1
   function automatic logic [3:0] gf_mul2(input logic [3:0] v);
      return {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
   endfunction

   // Multiply by 4 (x^2) in GF(2^4)
   function automatic logic [3:0] gf_mul4(input logic [3:0] v);
      return gf_mul2(gf_mul2(v));
   endfunction

   // Column {a,b} -> {a ^ 4b, b ^ 4a}; column 0 = [15:8], column 1 = [7:0]
   function automatic logic [15:0] mix_col(input logic [15:0] s);
      return {s[15:12] ^ gf_mul4(s[11:8]),
              s[11:8]  ^ gf_mul4(s[15:12]),
              s[7:4]   ^ gf_mul4(s[3:0]),
              s[3:0]   ^ gf_mul4(s[7:4])};
   endfunction

   // SubNib(RotNib(w)) for the key schedule
   function automatic logic [7:0] sub_rot8(input logic [7:0] w);
      return {sbox(w[3:0]), sbox(w[7:4])};
   endfunction

   state_t      state_r;
   logic [15:0] st_r;
   logic [15:0] key_r;
   logic [15:0] cipher_r;
   logic        out_valid_r;
   logic        busy_r;

   logic [7:0]  w2_s;
   logic [7:0]  w3_s;
   logic [7:0]  w4_s;
   logic [7:0]  w5_s;
   logic [15:0] k1_s;
   logic [15:0] k2_s;
   logic [15:0] round1_s;
   logic [15:0] round2_s;
   logic        in_ready_s;

   // Round keys derived combinationally from the captured key
   always_comb begin
      w2_s = key_r[15:8] ^ RCON1 ^ sub_rot8(key_r[7:0]);
      w3_s = w2_s ^ key_r[7:0];
      w4_s = w2_s ^ RCON2 ^ sub_rot8(w3_s);
      w5_s = w4_s ^ w3_s;
      k1_s = {w2_s, w3_s};
      k2_s = {w4_s, w5_s};
   end

   // Round datapaths: full round 1 and final round 2 (no MixColumns)
   always_comb begin
      round1_s = mix_col(shift_row(sub_nib16(st_r))) ^ k1_s;
      round2_s = shift_row(sub_nib16(st_r)) ^ k2_s;
   end

   // Ready when idle, or when the held result retires this cycle
   always_comb begin
      if (state_r == IDLE) begin
         in_ready_s = 1'b1;
      end else if (state_r == DONE) begin
         in_ready_s = bus.out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   // Control FSM with round state, captured key and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         st_r        <= 16'h0000;
         key_r       <= 16'h0000;
         cipher_r    <= 16'h0000;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  st_r    <= bus.Plain_Text ^ bus.Key;
                  key_r   <= bus.Key;
                  busy_r  <= 1'b1;
                  state_r <= ROUND1;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            ROUND1: begin
               st_r    <= round1_s;
               busy_r  <= 1'b1;
               state_r <= ROUND2;
            end
            ROUND2: begin
               cipher_r    <= round2_s;
               out_valid_r <= 1'b1;
               busy_r      <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  if (bus.in_valid) begin
                     // Retire and accept on the same edge: no idle bubble
                     st_r    <= bus.Plain_Text ^ bus.Key;
                     key_r   <= bus.Key;
                     busy_r  <= 1'b1;
                     state_r <= ROUND1;
                  end else begin
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end else begin
                  busy_r  <= 1'b1;
                  state_r <= DONE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.Cipher_Text = cipher_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.busy        = busy_r;

endmodule

// File: doc/simplified_aes_enc_iter.md
Name: simplified_aes_enc_iter

Overview:
- Iterative S-AES encryptor: 16-bit plaintext plus 16-bit key in, 16-bit ciphertext out; one round per clock.
- Forward counterpart of the combinational S-AES decryption datapath.
- Uses the same key schedule, round keys K0/K1/K2, and nibble/row ordering. Its ciphertext therefore round-trips through the decryptor to the original plaintext.
- Sits between a valid/ready plaintext source and a valid/ready ciphertext sink.

Parameters:
- RCON1, 8'h80, round constant XORed when deriving w2.
- RCON2, 8'h30, round constant XORed when deriving w4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Plain_Text  input  16  plaintext; nibble 0 = bits [15:12].
- Key  input  16  cipher key; w0 = [15:8], w1 = [7:0].
- in_valid  input  1  Plain_Text/Key valid.
- in_ready  output  1  block can accept an input this cycle.
- Cipher_Text  output  16  ciphertext; registered and stable while out_valid=1.
- out_valid  output  1  Cipher_Text valid.
- out_ready  input  1  sink accepts Cipher_Text.
- busy  output  1  high in ROUND1, ROUND2 and DONE.

Behaviour:
- Reset (async assert, sync deassert at the board level):
  - state=IDLE; Cipher_Text=16'h0000; out_valid=0; busy=0; internal state/key registers = 0.
  - in_ready=1 in the first cycle after reset releases.
- Arithmetic:
  - S-box (index 0..F): 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
  - ShiftRow: {n0,n1,n2,n3} -> {n0,n3,n2,n1}.
  - MixColumns: column {a,b} -> {a ^ 4*b, b ^ 4*a}, multiplication in GF(2^4) modulo x^4+x+1. Column 0 = bits [15:8], column 1 = bits [7:0].
  - Key schedule: w2 = w0 ^ RCON1 ^ SubNib(RotNib(w1)); w3 = w2 ^ w1; w4 = w2 ^ RCON2 ^ SubNib(RotNib(w3)); w5 = w4 ^ w3.
  - RotNib swaps the two nibbles. K0={w0,w1}, K1={w2,w3}, K2={w4,w5}.
- FSM states IDLE, ROUND1, ROUND2, DONE:
  - IDLE: in_ready=1. On in_valid: st <= Plain_Text ^ Key; key_q <= Key; -> ROUND1.
  - ROUND1: st <= MixCol(ShiftRow(SubNib(st))) ^ K1(key_q); -> ROUND2.
  - ROUND2: Cipher_Text <= ShiftRow(SubNib(st)) ^ K2(key_q); out_valid <= 1; -> DONE.
  - DONE: Cipher_Text and out_valid held until out_ready=1.
    - out_ready=1 and in_valid=0: out_valid <= 0; -> IDLE.
    - out_ready=1 and in_valid=1 in the same cycle: output retires and the new input is captured exactly as in IDLE; -> ROUND1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready.
- Latency: input handshake at edge T -> out_valid=1 after edge T+2. With out_ready held high, throughput is one block per 3 cycles.
- Inputs presented while in_ready=0 are ignored; there is no buffering.
- Plain_Text/Key are sampled only on the handshake edge. Later changes do not affect the block in flight.
- Cipher_Text is unchanged outside the ROUND2 update and reset; it keeps its last value after out_valid drops.
- rst asserted mid-operation (ROUND1/ROUND2/DONE): the block is discarded, out_valid falls immediately (async), and there is no partial output.
- K1/K2 are combinational from key_q; there is no key-expansion latency.

Test Plan:
- Vector 1: Plain_Text=16'hD728, Key=16'h4AF5, out_ready=1 -> after 3 cycles Cipher_Text=16'h24EC, out_valid high for one cycle, in_ready back to 1.
- Vector 2: Plain_Text=16'h6F6B, Key=16'hA73B -> Cipher_Text=16'h0738. Loopback: feed 16'h0738 with key 16'hA73B into the decryption block -> 16'h6F6B.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - Cipher_Text stays 16'h24EC, in_ready=0, new in_valid pulses are ignored.
  - Raising out_ready completes the transfer exactly once.
- Back-to-back: in DONE, out_ready=1 together with in_valid=1 (vector 2).
  - Vector 1 retires and vector 2 is captured on the same edge.
  - 16'h0738 appears 3 cycles later with no idle cycle.
- Reset mid-round: assert rst during ROUND2 of vector 1 -> out_valid=0, Cipher_Text=16'h0000, in_ready=1 after release. Vector 2 then yields 16'h0738.
- Input stability: change Plain_Text/Key in the cycle after the handshake -> result is still computed from the captured values (16'h24EC for vector 1).
